// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, default FIFO depth, the queued write entry and the grant encoding.
package regfile_arb_pkg;

  localparam int ADDR_W        = 5;
  localparam int DATA_W        = 32;
  localparam int DEFAULT_DEPTH = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    GRANT_R0 = 1'b0,
    GRANT_R1 = 1'b1
  } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester and register-file write bus of the writeback arbiter.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = regfile_arb_pkg::ADDR_W,
  parameter int DATA_W = regfile_arb_pkg::DATA_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write_signal;
  logic              busy;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  write_reg, write_data, reg_write_signal, busy
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output write_reg, write_data, reg_write_signal, busy
  );

endinterface

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// Small circular FIFO for one requester; push into a full FIFO and pop of an
// empty FIFO are ignored internally. Head entry is visible combinationally.
module wr_fifo
  import regfile_arb_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  parameter type T     = entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  T                         i_data,
  output T                         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file writeback arbiter: two requester FIFOs, one write per cycle,
// round-robin on ties, writes to register 0 are consumed without a strobe.
module regfile_write_arbiter #(
  parameter int DEPTH  = regfile_arb_pkg::DEFAULT_DEPTH,
  parameter int DATA_W = regfile_arb_pkg::DATA_W,
  parameter int ADDR_W = regfile_arb_pkg::ADDR_W
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  import regfile_arb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] data;
  } arb_entry_t;

  arb_entry_t       w_in0, w_in1, w_head0, w_head1, w_gnt_entry;
  logic             w_full0, w_full1, w_empty0, w_empty1;
  logic [CW-1:0]    w_count0, w_count1;
  logic             w_push0, w_push1, w_gnt0, w_gnt1;

  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_strobe;
  grant_t            r_last_grant;

  assign w_in0   = '{wreg: bus.req0_reg, data: bus.req0_data};
  assign w_in1   = '{wreg: bus.req1_reg, data: bus.req1_data};
  assign w_push0 = bus.req0_valid && !w_full0;
  assign w_push1 = bus.req1_valid && !w_full1;

  assign bus.req0_ready       = (w_count0 < CW'(DEPTH));
  assign bus.req1_ready       = (w_count1 < CW'(DEPTH));
  assign bus.write_reg        = r_write_reg;
  assign bus.write_data       = r_write_data;
  assign bus.reg_write_signal = r_strobe;
  assign bus.busy             = !w_empty0 || !w_empty1 || r_strobe;

  wr_fifo #(.DEPTH(DEPTH), .T(arb_entry_t)) u_fifo0 (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push0),
    .i_pop   (w_gnt0),
    .i_data  (w_in0),
    .o_head  (w_head0),
    .o_full  (w_full0),
    .o_empty (w_empty0),
    .o_count (w_count0)
  );

  wr_fifo #(.DEPTH(DEPTH), .T(arb_entry_t)) u_fifo1 (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push1),
    .i_pop   (w_gnt1),
    .i_data  (w_in1),
    .o_head  (w_head1),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_count (w_count1)
  );

  // Grant selection from pre-edge occupancy, so a just-pushed entry waits a cycle.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_gnt_entry = w_head0;
    if (!w_empty0 && (w_empty1 || r_last_grant == GRANT_R1)) begin
      w_gnt0 = 1'b1;
    end else if (!w_empty1) begin
      w_gnt1      = 1'b1;
      w_gnt_entry = w_head1;
    end
  end

  // Write port register and round-robin history, updated only on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_strobe     <= 1'b0;
      r_last_grant <= GRANT_R1;
    end else if (w_gnt0 || w_gnt1) begin
      r_write_reg  <= w_gnt_entry.wreg;
      r_write_data <= w_gnt_entry.data;
      r_strobe     <= (w_gnt_entry.wreg != '0);
      r_last_grant <= w_gnt0 ? GRANT_R0 : GRANT_R1;
    end else begin
      r_strobe <= 1'b0;
    end
  end

endmodule
